sample_capture: RTL and testbench
=================================

# sample_capture

Acquisition buffer that consumes the one-cycle trigger pulse from the trigger controller and stores a pre-/post-trigger window of 8-bit ADC samples in a circular RAM. After the window is complete, it holds the record for readout by the display/UART side. It sits between the ADC data path, the trigger controller and the waveform reader. Sampling rate is set by a programmable clock-enable divider (timebase).

## Interface
- DATA_W, 8, sample width
- DEPTH_LOG2, 8, log2 of buffer depth; DEPTH = 2^DEPTH_LOG2; AW = DEPTH_LOG2

Ports:
- clk_20M  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- data  input  DATA_W  ADC sample, written raw on each sample strobe
- trigger_activation  input  1  one-cycle trigger pulse
- force_trig  input  1  one-cycle manual/auto trigger, equivalent to trigger_activation
- arm  input  1  one-cycle pulse; starts a new acquisition
- pre_trig  input  AW  pre-trigger sample count P, 0..DEPTH-1, captured on arm
- sample_div  input  16  strobe every sample_div+1 clocks, captured on arm
- rd_en  input  1  read request
- rd_addr  input  AW  logical index k; 0 = oldest sample of the record
- rd_data  output  DATA_W  registered read data
- trig_addr  output  AW  physical RAM address of the trigger sample
- busy  output  1  high in PRE, WAIT_TRIG, POST
- done  output  1  high in DONE

## Operation
- RAM: DEPTH x DATA_W simple dual-port, one write port and one read port. wr_ptr is AW bits and wraps DEPTH-1 -> 0.
- Strobe: div_cnt counts 0..sample_div, strobe when div_cnt == sample_div, then div_cnt returns to 0. div_cnt clears on arm. sample_div = 0 gives a strobe every clock.
- Each strobe in PRE, WAIT_TRIG or POST writes data to mem[wr_ptr] and increments wr_ptr. No writes in IDLE or DONE.
- States:
  - IDLE: waits for arm.
  - arm (accepted in any state): captures P and sample_div; clears div_cnt, pre_cnt and post_cnt; goes to PRE if P>0, else WAIT_TRIG.
  - PRE: each write increments pre_cnt. The write that makes pre_cnt == P moves to WAIT_TRIG. Trigger pulses in PRE are ignored.
  - WAIT_TRIG: writes continue circularly. trigger_activation or force_trig moves to POST on the next cycle. A write in the pulse cycle counts as a pre-trigger sample.
  - POST: the first write is the trigger sample, and trig_addr latches its wr_ptr. Each write increments post_cnt. The write that makes post_cnt == DEPTH-P moves to DONE.
  - DONE: holds until arm.
- arm takes priority over a trigger in the same cycle; that trigger is lost.
- Record start address = (trig_addr - P) mod DEPTH.
- Read: rd_data <= mem[(start + rd_addr) mod DEPTH], where start is the record start address above. Additions are AW bits wide and wrap naturally.
- Reads are legal in any state; contents are defined only in DONE. rd_data holds its value when rd_en is low.
- The trigger pulse lags the level crossing by 2 clocks. Alignment of data to the trigger is the upstream's responsibility.

## Timing
- Reset values: state IDLE; busy 0; done 0; rd_data 0; trig_addr 0; wr_ptr 0; div_cnt 0; pre_cnt 0; post_cnt 0.
- arm at cycle T: busy = 1 at T+1. With div 0, the first write happens at T+1.
- With div 0 and P>0: writes in T+1..T+P, and WAIT_TRIG starts at T+P+1.
- Trigger pulse at cycle X in WAIT_TRIG with div 0: POST writes occur in X+1..X+DEPTH-P; done = 1 and busy = 0 at X+DEPTH-P+1.
- With divider D = sample_div+1: post writes occur on strobes only, so done lags the trigger by about (DEPTH-P)*D cycles.
- Read latency is 1 clock (rd_en at R -> rd_data valid at R+1). Back-to-back reads are allowed every cycle.
- arm in DONE: done = 0 and busy = 1 at the next cycle.
- Reset mid-acquisition aborts immediately to the reset values. RAM contents are undefined.

## Test plan
- Reset: assert rst_n = 0 mid-POST -> busy = 0, done = 0, rd_data = 0, trig_addr = 0 asynchronously; no writes occur afterward until arm.
- Basic window (DEPTH_LOG2 = 4, P = 4, div 0): drive data as a ramp of +1 per clock starting at 0 on the arm cycle; pulse the trigger when data = 50 -> done 13 cycles later; rd_addr k returns 47+k for k = 0..15; index 4 = 51.
- Trigger during PRE: P = 8, pulse at the 3rd PRE write -> stays in PRE/WAIT_TRIG, done stays 0; a later pulse completes a normal capture.
- Decimation: sample_div = 3, P = 2, DEPTH 16 -> writes every 4th clock; done 56 clocks after the POST entry cycle; record holds every 4th ramp value.
- P = 0 with force_trig: arm, then force_trig on the next cycle -> index 0 = trigger sample, trig_addr = start.
- Wrap and priority:
  - Wait more than 40 strobes in WAIT_TRIG, then trigger -> start wraps correctly and reads stay contiguous.
  - arm and trigger in the same cycle -> restart, trigger ignored.
  - arm mid-POST -> done never asserts for the aborted capture.

Source files
------------

// File: rtl/sample_capture.sv
// Pre-/post-trigger acquisition buffer.
// Writes decimated ADC samples into a circular RAM. Once a trigger arrives,
// it keeps a window of P samples before the trigger and DEPTH-P samples from
// the trigger on. The finished record is then held for readout.
module sample_capture #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk_20M,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data,
  input  logic                  trigger_activation,
  input  logic                  force_trig,
  input  logic                  arm,
  input  logic [DEPTH_LOG2-1:0] pre_trig,
  input  logic [15:0]           sample_div,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [15:0]   div_cnt_reg;
  logic [15:0]   div_reg;
  logic [AW-1:0] pre_p_reg;
  logic [AW-1:0] pre_cnt_reg;
  logic [AW:0]   post_cnt_reg;
  logic [AW-1:0] trig_addr_reg;
  logic [DATA_W-1:0] rd_data_reg;

  logic          strobe;
  logic          capturing;
  logic          wr_en;
  logic          trig_pulse;
  logic [AW-1:0] pre_cnt_inc;
  logic [AW:0]   post_cnt_inc;
  logic [AW:0]   post_len;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] rd_ptr;

  assign strobe       = (div_cnt_reg == div_reg);
  assign capturing    = (state_reg == S_PRE) || (state_reg == S_WAIT_TRIG) || (state_reg == S_POST);
  // The arm cycle restarts the record, so a strobe coinciding with it is dropped.
  assign wr_en        = strobe && capturing && !arm;
  assign trig_pulse   = trigger_activation | force_trig;
  assign pre_cnt_inc  = pre_cnt_reg + AW'(1);
  assign post_cnt_inc = post_cnt_reg + (AW+1)'(1);
  assign post_len     = (AW+1)'(DEPTH) - {1'b0, pre_p_reg};
  // Oldest sample of the record sits P entries before the trigger sample.
  assign start_addr   = trig_addr_reg - pre_p_reg;
  assign rd_ptr       = start_addr + rd_addr;

  // Next-state and status decode; arm overrides everything, including a trigger.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: ;
      S_PRE: begin
        busy = 1'b1;
        if (wr_en && (pre_cnt_inc == pre_p_reg)) state_next = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        busy = 1'b1;
        if (trig_pulse) state_next = S_POST;
      end
      S_POST: begin
        busy = 1'b1;
        if (wr_en && (post_cnt_inc == post_len)) state_next = S_DONE;
      end
      S_DONE: done = 1'b1;
      default: state_next = S_IDLE;
    endcase
    if (arm) state_next = (pre_trig != '0) ? S_PRE : S_WAIT_TRIG;
  end

  // State register, timebase divider, write pointer and window counters.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      div_cnt_reg   <= '0;
      div_reg       <= '0;
      pre_p_reg     <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      trig_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (arm) begin
        pre_p_reg    <= pre_trig;
        div_reg      <= sample_div;
        div_cnt_reg  <= '0;
        pre_cnt_reg  <= '0;
        post_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= strobe ? 16'd0 : div_cnt_reg + 16'd1;
        if (wr_en) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (state_reg == S_PRE) pre_cnt_reg <= pre_cnt_inc;
          if (state_reg == S_POST) begin
            post_cnt_reg <= post_cnt_inc;
            // First post-trigger write is the trigger sample itself.
            if (post_cnt_reg == '0) trig_addr_reg <= wr_ptr_reg;
          end
        end
      end
    end
  end

  // Sample RAM write port (contents are not reset).
  always_ff @(posedge clk_20M) begin
    if (wr_en) mem[wr_ptr_reg] <= data;
  end

  // Registered read port addressed relative to the record start.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_ptr];
  end

  assign rd_data   = rd_data_reg;
  assign trig_addr = trig_addr_reg;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with a 16-entry buffer and a ramp input.
module tb_sample_capture;

  logic        clk_20M = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        trigger_activation;
  logic        force_trig;
  logic        arm;
  logic [3:0]  pre_trig;
  logic [15:0] sample_div;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [3:0]  trig_addr;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int rel    = 0;
  logic [7:0] exp_q [$];

  sample_capture #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk_20M            (clk_20M),
    .rst_n              (rst_n),
    .data               (data),
    .trigger_activation (trigger_activation),
    .force_trig         (force_trig),
    .arm                (arm),
    .pre_trig           (pre_trig),
    .sample_div         (sample_div),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .trig_addr          (trig_addr),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk_20M = ~clk_20M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge; ramp advances by one.
  task automatic tick();
    @(posedge clk_20M);
    #1;
    data               = data + 8'd1;
    arm                = 1'b0;
    trigger_activation = 1'b0;
    force_trig         = 1'b0;
    rel++;
  endtask

  // Arm edge becomes rel 0; ramp value sampled on that edge is 0.
  task automatic start(input logic [3:0] p, input logic [15:0] div);
    arm        = 1'b1;
    pre_trig   = p;
    sample_div = div;
    data       = 8'd0;
    rel        = -1;
    tick();
  endtask

  task automatic pulse_at(input int e, input bit use_force);
    while (rel < e - 1) tick();
    if (use_force) force_trig = 1'b1;
    else trigger_activation = 1'b1;
    tick();
  endtask

  task automatic expect_done_at(input int e, input string tag);
    while (rel < e - 1) tick();
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  // Back-to-back reads of the whole record; the last value must then hold.
  task automatic check_record(input int base, input int stepv, input string tag);
    logic [7:0] got;
    logic [7:0] last;
    last = 8'd0;
    for (int k = 0; k < 16; k++) begin
      rd_en   = 1'b1;
      rd_addr = k[3:0];
      exp_q.push_back(8'(base + stepv * k));
      tick();
      got  = exp_q.pop_front();
      last = got;
      $display("read %s k=%0d data=%0d expected=%0d", tag, k, rd_data, got);
      chk({tag, "_rd"}, 32'(rd_data), 32'(got));
    end
    rd_en   = 1'b0;
    rd_addr = 4'd0;
    tick();
    chk({tag, "_rd_hold"}, 32'(rd_data), 32'(last));
  endtask

  initial begin
    rst_n              = 1'b0;
    data               = 8'd0;
    trigger_activation = 1'b0;
    force_trig         = 1'b0;
    arm                = 1'b0;
    pre_trig           = 4'd0;
    sample_div         = 16'd0;
    rd_en              = 1'b0;
    rd_addr            = 4'd0;

    repeat (3) @(posedge clk_20M);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_trig_addr", 32'(trig_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic window: P=4, trigger when the ramp reads 50.
    start(4'd4, 16'd0);
    chk("basic_busy_after_arm", 32'(busy), 32'd1);
    pulse_at(50, 1'b0);
    expect_done_at(62, "basic");
    chk("basic_trig_addr", 32'(trig_addr), 32'd2);
    check_record(47, 1, "basic");

    // Trigger during PRE must be ignored.
    start(4'd8, 16'd0);
    pulse_at(3, 1'b0);
    chk("pre_busy", 32'(busy), 32'd1);
    chk("pre_done", 32'(done), 32'd0);
    while (rel < 15) tick();
    chk("pre_still_busy", 32'(busy), 32'd1);
    chk("pre_still_not_done", 32'(done), 32'd0);
    pulse_at(20, 1'b0);
    expect_done_at(28, "pretrig");
    check_record(13, 1, "pretrig");

    // Long wait in WAIT_TRIG wraps the pointer several times.
    start(4'd4, 16'd0);
    pulse_at(60, 1'b0);
    expect_done_at(72, "wrap");
    check_record(57, 1, "wrap");

    // arm and trigger in the same cycle: restart, trigger lost.
    start(4'd4, 16'd0);
    while (rel < 19) tick();
    trigger_activation = 1'b1;
    start(4'd4, 16'd0);
    while (rel < 20) tick();
    chk("armtrig_busy", 32'(busy), 32'd1);
    chk("armtrig_done", 32'(done), 32'd0);
    pulse_at(30, 1'b0);
    expect_done_at(42, "armtrig");
    check_record(27, 1, "armtrig");

    // arm mid-POST aborts; done must not appear for the aborted capture.
    start(4'd4, 16'd0);
    pulse_at(10, 1'b0);
    while (rel < 14) tick();
    start(4'd4, 16'd0);
    for (int i = 0; i < 6; i++) begin
      repeat (5) tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    pulse_at(40, 1'b0);
    expect_done_at(52, "abort");
    check_record(37, 1, "abort");

    // Asynchronous reset mid-POST.
    start(4'd4, 16'd0);
    pulse_at(10, 1'b0);
    while (rel < 15) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    chk("midreset_trig_addr", 32'(trig_addr), 32'd0);
    @(negedge clk_20M);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("postreset_busy", 32'(busy), 32'd0);
    chk("postreset_done", 32'(done), 32'd0);

    // P=0 with force_trig right after arm; pointer restarted at 0 by reset.
    start(4'd0, 16'd0);
    pulse_at(1, 1'b1);
    expect_done_at(17, "p0");
    chk("p0_trig_addr", 32'(trig_addr), 32'd1);
    check_record(2, 1, "p0");

    // Decimation by 4 with P=2; trigger lands on a strobe.
    start(4'd2, 16'd3);
    pulse_at(20, 1'b0);
    expect_done_at(76, "decim");
    check_record(16, 4, "decim");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
